// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through cache:
// FSM encoding, word size and address field-width helpers.
package cache_pkg;
    localparam int CACHE_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2
    } cache_state_t;

    function automatic int offset_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int index_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_bits(input int addr_width, input int num_lines, input int words_per_line);
        return addr_width - index_bits(num_lines) - offset_bits(words_per_line) - $clog2(CACHE_WORD_BYTES);
    endfunction
endpackage

// File: rtl/cache_data_array.sv
// Line storage for the cache: NUM_LINES x WORDS_PER_LINE words,
// combinational read and a single clocked word write port.
module cache_data_array
    import cache_pkg::*;
#(
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                   clk,
    input  logic                                   we,
    input  logic [index_bits(NUM_LINES)-1:0]       wr_index,
    input  logic [offset_bits(WORDS_PER_LINE)-1:0] wr_word,
    input  logic [31:0]                            wr_data,
    input  logic [index_bits(NUM_LINES)-1:0]       rd_index,
    input  logic [offset_bits(WORDS_PER_LINE)-1:0] rd_word,
    output logic [31:0]                            rd_data
);
    logic [31:0] mem [NUM_LINES][WORDS_PER_LINE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_index][wr_word] <= wr_data;
        end
    end

    assign rd_data = mem[rd_index][rd_word];
endmodule

// File: rtl/dm_cache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache between the
// CPU MEM stage and a word-wide req/ready backing memory.
module dm_cache_wt
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);
    localparam int LO_W  = $clog2(CACHE_WORD_BYTES);
    localparam int OFF_W = offset_bits(WORDS_PER_LINE);
    localparam int IDX_W = index_bits(NUM_LINES);
    localparam int TAG_W = tag_bits(ADDR_WIDTH, NUM_LINES, WORDS_PER_LINE);

    cache_state_t     state, next_state;
    logic [TAG_W-1:0] tag_ram [NUM_LINES];
    logic [NUM_LINES-1:0] valid;
    logic [OFF_W-1:0] beat;
    logic             refill_done_q;

    logic [OFF_W-1:0] word;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic             unused_addr_bits;
    logic             hit, rd_req, wr_req, last_beat;
    logic [31:0]      line_word;
    logic             arr_we;
    logic [OFF_W-1:0] arr_word;
    logic [31:0]      arr_wdata;

    assign word             = address[OFF_W+LO_W-1:LO_W];
    assign index            = address[IDX_W+OFF_W+LO_W-1:OFF_W+LO_W];
    assign tag              = address[ADDR_WIDTH-1:IDX_W+OFF_W+LO_W];
    assign unused_addr_bits = ^address[LO_W-1:0];

    assign hit       = valid[index] && (tag_ram[index] == tag);
    assign wr_req    = MemWrite;
    assign rd_req    = MemRead && !MemWrite;
    assign last_beat = (beat == OFF_W'(WORDS_PER_LINE - 1));

    cache_data_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_data (
        .clk      (clk),
        .we       (arr_we),
        .wr_index (index),
        .wr_word  (arr_word),
        .wr_data  (arr_wdata),
        .rd_index (index),
        .rd_word  (word),
        .rd_data  (line_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (wr_req) begin
                    next_state = ST_WRITE;
                end else if (rd_req && !hit) begin
                    next_state = ST_REFILL;
                end
            end
            ST_REFILL: if (mem_ready && last_beat) next_state = ST_IDLE;
            ST_WRITE:  if (mem_ready) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        read_data = '0;
        arr_we    = 1'b0;
        arr_word  = word;
        arr_wdata = write_data;
        unique case (state)
            ST_IDLE: begin
                if (wr_req || (rd_req && !hit)) begin
                    stall = 1'b1;
                end else if (rd_req) begin
                    read_data = line_word;
                end
            end
            ST_REFILL: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = {tag, index, beat, {LO_W{1'b0}}};
                arr_we    = mem_ready;
                arr_word  = beat;
                arr_wdata = mem_rdata;
            end
            ST_WRITE: begin
                // The store retires in the cycle the backing memory accepts it.
                stall     = !mem_ready;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {address[ADDR_WIDTH-1:LO_W], {LO_W{1'b0}}};
                mem_wdata = write_data;
                arr_we    = mem_ready && hit;
            end
            default: ;
        endcase
    end

    // The hit seen right after a refill is the same access that already counted as a miss.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid         <= '0;
            beat          <= '0;
            refill_done_q <= 1'b0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            refill_done_q <= 1'b0;
            if (state == ST_IDLE && rd_req) begin
                if (!hit) begin
                    beat <= '0;
                    if (miss_count != '1) miss_count <= miss_count + 32'd1;
                end else if (!refill_done_q && hit_count != '1) begin
                    hit_count <= hit_count + 32'd1;
                end
            end
            if (state == ST_REFILL && mem_ready) begin
                beat <= beat + 1'b1;
                if (last_beat) begin
                    valid[index]  <= 1'b1;
                    refill_done_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state == ST_REFILL && mem_ready && last_beat) begin
            tag_ram[index] <= tag;
        end
    end
endmodule

// File: tb/tb_dm_cache_wt.sv
// Directed bench for dm_cache_wt with a req/ready backing-memory responder
// (optional ready delay) that logs every accepted beat.
module tb_dm_cache_wt;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    beat_t       beats[$];
    logic [31:0] bmem [logic [31:0]];
    int          ready_delay = 0;
    int          wait_cnt = 0;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    dm_cache_wt #(
        .ADDR_WIDTH     (32),
        .NUM_LINES      (64),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    function automatic logic [31:0] backing_word(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return {16'hC0DE, a[15:0]};
    endfunction

    // Backing memory: answers after ready_delay idle cycles, logs accepted beats before the edge.
    always @(negedge clk) begin
        #1;
        if (mem_req === 1'b1 && reset === 1'b0) begin
            if (wait_cnt >= ready_delay) begin
                mem_ready = 1'b1;
                wait_cnt  = 0;
            end else begin
                mem_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end
        mem_rdata = backing_word(mem_addr);
        #1;
        if (mem_req === 1'b1 && mem_ready === 1'b1) begin
            beats.push_back('{mem_we, mem_addr, mem_wdata});
            if (mem_we) bmem[mem_addr] = mem_wdata;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        MemRead    = rd;
        MemWrite   = wr;
        address    = addr;
        write_data = wdata;
        #4;
    endtask

    task automatic step_cycle();
        @(negedge clk);
        #4;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #4;
    endtask

    task automatic wait_unstall(input string tag);
        int n = 0;
        while (stall !== 1'b0 && n < 200) begin
            step_cycle();
            n++;
        end
        check_output({tag, "_unstall"}, 32'(stall), 32'd0);
    endtask

    task automatic check_refill(input string tag, input logic [31:0] base);
        check_output({tag, "_beats"}, 32'(beats.size()), 32'd4);
        if (beats.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check_output($sformatf("%s_beat%0d_addr", tag, i), beats[i].addr, base + 32'(i * 4));
                check_output($sformatf("%s_beat%0d_we", tag, i), 32'(beats[i].we), 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int stall_cycles;
        int addr_changes;
        int n;
        logic [31:0] prev_addr;
        logic prev_req, prev_ready;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #4;
        check_output("reset_stall", 32'(stall), 32'd0);
        check_output("reset_mem_req", 32'(mem_req), 32'd0);
        check_output("reset_read_data", read_data, 32'd0);
        check_output("reset_hits", hit_count, 32'd0);
        check_output("reset_misses", miss_count, 32'd0);

        // Cold read miss, then refill and same-cycle data
        beats.delete();
        apply_stimulus(1'b1, 1'b0, 32'h100, 32'h0);
        check_output("miss100_stall", 32'(stall), 32'd1);
        wait_unstall("miss100");
        check_output("miss100_data", read_data, 32'hC0DE0100);
        check_refill("miss100", 32'h100);
        check_output("miss100_misses", miss_count, 32'd1);
        check_output("miss100_hits", hit_count, 32'd0);

        apply_stimulus(1'b1, 1'b0, 32'h108, 32'h0);
        check_output("hit108_data", read_data, 32'hC0DE0108);
        check_output("hit108_stall", 32'(stall), 32'd0);
        check_output("hit108_mem_req", 32'(mem_req), 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
        check_output("hit108_hits", hit_count, 32'd1);
        check_output("idle_read_data", read_data, 32'd0);

        // Store hit: one write beat, cached word updated
        beats.delete();
        apply_stimulus(1'b0, 1'b1, 32'h104, 32'hDEADBEEF);
        check_output("st104_stall", 32'(stall), 32'd1);
        wait_unstall("st104");
        check_output("st104_mem_req", 32'(mem_req), 32'd1);
        check_output("st104_mem_we", 32'(mem_we), 32'd1);
        check_output("st104_mem_addr", mem_addr, 32'h104);
        check_output("st104_mem_wdata", mem_wdata, 32'hDEADBEEF);
        apply_stimulus(1'b1, 1'b0, 32'h104, 32'h0);
        check_output("ld104_data", read_data, 32'hDEADBEEF);
        check_output("ld104_stall", 32'(stall), 32'd0);
        check_output("st104_beats", 32'(beats.size()), 32'd1);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
        check_output("ld104_hits", hit_count, 32'd2);
        check_output("ld104_misses", miss_count, 32'd1);

        // Store miss: write-through only, no allocation
        beats.delete();
        apply_stimulus(1'b0, 1'b1, 32'h2000, 32'h12345678);
        wait_unstall("st2000");
        check_output("st2000_mem_addr", mem_addr, 32'h2000);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
        check_output("st2000_beats", 32'(beats.size()), 32'd1);
        beats.delete();
        apply_stimulus(1'b1, 1'b0, 32'h2000, 32'h0);
        check_output("ld2000_stall", 32'(stall), 32'd1);
        wait_unstall("ld2000");
        check_output("ld2000_data", read_data, 32'h12345678);
        check_refill("ld2000", 32'h2000);
        check_output("ld2000_misses", miss_count, 32'd2);
        apply_stimulus(1'b1, 1'b0, 32'h2004, 32'h0);
        check_output("ld2004_data", read_data, 32'hC0DE2004);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
        check_output("ld2004_hits", hit_count, 32'd3);

        // Slow memory: three idle cycles before each beat
        ready_delay = 3;
        beats.delete();
        apply_stimulus(1'b1, 1'b0, 32'h3040, 32'h0);
        stall_cycles = (stall === 1'b1) ? 1 : 0;
        addr_changes = 0;
        n = 0;
        while (stall === 1'b1 && n < 200) begin
            prev_addr  = mem_addr;
            prev_req   = mem_req;
            prev_ready = mem_ready;
            step_cycle();
            if (prev_req && !prev_ready && mem_req && mem_addr !== prev_addr) addr_changes++;
            if (stall === 1'b1) stall_cycles++;
            n++;
        end
        check_output("slow_unstall", 32'(stall), 32'd0);
        check_output("slow_stall_cycles", 32'(stall_cycles), 32'd17);
        check_output("slow_addr_changes", 32'(addr_changes), 32'd0);
        check_output("slow_data", read_data, 32'hC0DE3040);
        check_refill("slow", 32'h3040);
        ready_delay = 0;

        // Reset in the middle of a refill
        beats.delete();
        apply_stimulus(1'b1, 1'b0, 32'h700, 32'h0);
        step_cycle();
        step_cycle();
        check_output("midrst_beats_before", 32'(beats.size()), 32'd2);
        pulse_reset();
        check_output("midrst_mem_req", 32'(mem_req), 32'd0);
        check_output("midrst_mem_we", 32'(mem_we), 32'd0);
        check_output("midrst_stall", 32'(stall), 32'd1);
        check_output("midrst_misses", miss_count, 32'd0);
        check_output("midrst_hits", hit_count, 32'd0);
        beats.delete();
        wait_unstall("midrst");
        check_output("midrst_data", read_data, 32'hC0DE0700);
        check_refill("midrst", 32'h700);
        check_output("midrst_misses_after", miss_count, 32'd1);

        // Conflict misses on the same index
        pulse_reset();
        beats.delete();
        apply_stimulus(1'b1, 1'b0, 32'h100, 32'h0);
        check_output("conf1_stall", 32'(stall), 32'd1);
        wait_unstall("conf1");
        check_output("conf1_data", read_data, 32'hC0DE0100);
        check_refill("conf1", 32'h100);
        beats.delete();
        apply_stimulus(1'b1, 1'b0, 32'h500, 32'h0);
        check_output("conf2_stall", 32'(stall), 32'd1);
        wait_unstall("conf2");
        check_output("conf2_data", read_data, 32'hC0DE0500);
        check_refill("conf2", 32'h500);
        beats.delete();
        apply_stimulus(1'b1, 1'b0, 32'h100, 32'h0);
        check_output("conf3_stall", 32'(stall), 32'd1);
        wait_unstall("conf3");
        check_output("conf3_data", read_data, 32'hC0DE0100);
        check_refill("conf3", 32'h100);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
        check_output("conf_misses", miss_count, 32'd3);
        check_output("conf_hits", hit_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
